mem_port_sequencer: RTL and testbench
=====================================

Name: mem_port_sequencer

Overview:
Sequences the multicycle CPU's single memory port. Drives the IorD address-select mux and the memory write enable, and arbitrates between three requesters: instruction fetch, data load/store and exception vector read. Sits between the main control FSM and the memory-address mux. Emits the one-cycle load strobes for IR, MDR and the PC exception-handler load.

Parameters:
MEM_LAT, 1, memory access latency in cycles (legal range 1..15); number of ACCESS cycles
CNT_W, 4, width of the latency counter; must satisfy 2**CNT_W > MEM_LAT

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
fetch_req  in  1  level request: read the instruction at the PC (mux sel 000)
data_req  in  1  level request: data access
data_wr  in  1  qualifies data_req; 1 = store, 0 = load
data_addr_src  in  1  address source for data access; 0 = alu_out (sel 001), 1 = result (sel 010)
exc_req  in  1  level request: exception vector read
exc_code  in  2  00 = invalid opcode (addr 253, sel 011); 01 = overflow (254, sel 100); 10 = divide by zero (255, sel 101); 11 reserved, treated as 00
iord_sel  out  3  memory-address mux select
mem_wr  out  1  memory write enable
ir_wr  out  1  one-cycle pulse: instruction register load
mdr_wr  out  1  one-cycle pulse: memory data register load
epc_wr  out  1  one-cycle pulse: EPC capture at exception grant
pc_exc_load  out  1  one-cycle pulse: PC loads the handler byte
busy  out  1  high in ACCESS and COMPLETE states
done  out  1  one-cycle pulse at completion of any granted access

Behaviour:
- Reset is asynchronous and active-high.
  - Sets state to IDLE and clears the counter and captured request.
  - All outputs go to 0, including iord_sel = 000.
  - Reset mid-access aborts the access: no completion pulse is emitted and mem_wr drops immediately.
- States: IDLE, ACCESS, COMPLETE.
- IDLE:
  - iord_sel = 000 and busy = 0.
  - Requests are sampled every cycle. Fixed priority: exc_req > data_req > fetch_req.
  - On a grant: capture the requester, data_wr, data_addr_src and exc_code; load the counter with MEM_LAT-1; go to ACCESS.
  - If the granted request is an exception, epc_wr pulses in the grant cycle.
  - No request: stay in IDLE.
- ACCESS:
  - iord_sel is held at the captured encoding throughout.
  - mem_wr = 1 only in the first ACCESS cycle, and only for a granted store.
  - The counter decrements each cycle. At counter = 0, go to COMPLETE.
  - ACCESS therefore lasts exactly MEM_LAT cycles.
- COMPLETE, one cycle:
  - iord_sel is still held.
  - done = 1, plus exactly one of:
    - ir_wr (fetch)
    - mdr_wr (load)
    - pc_exc_load (exception)
    - nothing extra (store)
  - Next state is IDLE.
- Latency: from a grant in IDLE cycle t, done rises in cycle t+MEM_LAT+1. The earliest next grant is t+MEM_LAT+2.
- Requests are level-sensitive. A requester must deassert in the cycle after done, otherwise it is granted again.
- Requests arriving while busy are ignored and are not queued (but see the optional feature).
- Changes to data_wr, data_addr_src or exc_code during busy have no effect.
- Simultaneous requests in IDLE: only the highest priority is granted. Lower-priority requests keep waiting.
- Encodings 110 and 111 are never driven on iord_sel.

Optional Feature:
- Macro: MEM_PORT_EXC_LATCH_EN
- When defined:
  - An exc_req rising while busy sets a pending flag and captures exc_code; a later pulse overwrites the captured code.
  - In the COMPLETE cycle, the pending flag forces the next state to ACCESS with an exception grant and an epc_wr pulse, bypassing IDLE.
  - The pending flag clears on that grant.
  - Reset clears the pending flag.
- When undefined: exc_req is sampled only in IDLE, as specified above.

Decomposition:
- Shared package mem_port_pkg contains:
  - iord_sel encodings (SEL_PC = 000, SEL_ALU = 001, SEL_RESULT = 010, SEL_VEC253 = 011, SEL_VEC254 = 100, SEL_VEC255 = 101)
  - exc_code constants
  - state enum (IDLE, ACCESS, COMPLETE)
  - requester-id enum (REQ_FETCH, REQ_LOAD, REQ_STORE, REQ_EXC)
- One natural sub-module: mem_lat_counter, a loadable down-counter with a zero flag, CNT_W wide.

Test Plan:
- MEM_LAT = 2; fetch_req pulsed in cycle 1 → iord_sel = 000 in cycles 2–4; ir_wr = 1 and done = 1 in cycle 4 only; busy = 1 in cycles 2–4.
- data_req = 1, data_wr = 1, data_addr_src = 1 → iord_sel = 010; mem_wr = 1 in the first ACCESS cycle only; done with no ir_wr, mdr_wr or pc_exc_load.
- exc_req, data_req and fetch_req all high with exc_code = 01 → epc_wr pulses in the grant cycle; iord_sel = 100; pc_exc_load at completion. With all three held, data is served next, then fetch; exc_code = 11 selects 011.
- Load in progress, reset asserted in its second ACCESS cycle → all outputs 0 asynchronously; no mdr_wr or done; the next grant succeeds after reset release.
- With MEM_PORT_EXC_LATCH_EN and MEM_LAT = 3: exc_req pulsed (exc_code = 10) during a fetch → ir_wr, then a direct exception grant with iord_sel = 101 and no IDLE cycle. Without the macro, the same stimulus produces only ir_wr.

Source files
------------

// File: rtl/mem_port_pkg.sv
// Shared definitions for the memory-port sequencer: address-mux encodings,
// exception codes, FSM states and requester ids.
package mem_port_pkg;

  // Memory-address (IorD) mux select encodings; 110/111 are never driven.
  localparam logic [2:0] SEL_PC     = 3'b000;
  localparam logic [2:0] SEL_ALU    = 3'b001;
  localparam logic [2:0] SEL_RESULT = 3'b010;
  localparam logic [2:0] SEL_VEC253 = 3'b011;
  localparam logic [2:0] SEL_VEC254 = 3'b100;
  localparam logic [2:0] SEL_VEC255 = 3'b101;

  // Exception codes presented with exc_req.
  localparam logic [1:0] EXC_INVALID = 2'b00;
  localparam logic [1:0] EXC_OVF     = 2'b01;
  localparam logic [1:0] EXC_DIV0    = 2'b10;
  localparam logic [1:0] EXC_RSVD    = 2'b11;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACCESS   = 2'd1,
    COMPLETE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    REQ_FETCH = 2'd0,
    REQ_LOAD  = 2'd1,
    REQ_STORE = 2'd2,
    REQ_EXC   = 2'd3
  } req_t;

  // Vector byte select for an exception code; the reserved code reads the
  // invalid-opcode vector.
  function automatic logic [2:0] exc_vec_sel(input logic [1:0] code);
    case (code)
      EXC_OVF:  return SEL_VEC254;
      EXC_DIV0: return SEL_VEC255;
      default:  return SEL_VEC253;
    endcase
  endfunction

endpackage

// File: rtl/mem_lat_counter.sv
// Loadable down-counter with zero flag; times the ACCESS phase of a memory
// transaction. Load wins over decrement; it never wraps below zero.
module mem_lat_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  // Load on grant, otherwise count down while enabled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/mem_port_sequencer.sv
// Memory-port sequencer for the multicycle CPU. Arbitrates fetch, data and
// exception-vector requests (exc > data > fetch), drives the IorD select and
// memory write enable, and emits the IR/MDR/PC-handler load strobes.
// Optional: define MEM_PORT_EXC_LATCH_EN to latch an exception request that
// rises while busy and grant it straight from COMPLETE.
//
// Handshake: requests are levels sampled only when the sequencer is idle (or,
// with the latch option, exc_req rising edges while busy); a grant is taken in
// the IDLE cycle the request is seen, done pulses MEM_LAT+1 cycles later, and a
// requester still high in the cycle after done is granted again.
module mem_port_sequencer
  import mem_port_pkg::*;
#(
  parameter int MEM_LAT = 1,
  parameter int CNT_W   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       fetch_req,
  input  logic       data_req,
  input  logic       data_wr,
  input  logic       data_addr_src,
  input  logic       exc_req,
  input  logic [1:0] exc_code,
  output logic [2:0] iord_sel,
  output logic       mem_wr,
  output logic       ir_wr,
  output logic       mdr_wr,
  output logic       epc_wr,
  output logic       pc_exc_load,
  output logic       busy,
  output logic       done
);

  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(MEM_LAT - 1);

  state_t     state;
  req_t       cur_req;
  logic       grant;
  req_t       grant_req;
  logic [2:0] grant_sel;
  logic       chain_exc;
  logic [2:0] chain_sel;
  logic       cnt_zero;

  // Fixed-priority arbitration of the requests seen in IDLE.
  always_comb begin
    grant     = 1'b0;
    grant_req = REQ_FETCH;
    grant_sel = SEL_PC;
    if (state == IDLE) begin
      if (exc_req) begin
        grant     = 1'b1;
        grant_req = REQ_EXC;
        grant_sel = exc_vec_sel(exc_code);
      end else if (data_req) begin
        grant     = 1'b1;
        grant_req = data_wr ? REQ_STORE : REQ_LOAD;
        grant_sel = data_addr_src ? SEL_RESULT : SEL_ALU;
      end else if (fetch_req) begin
        grant     = 1'b1;
        grant_req = REQ_FETCH;
        grant_sel = SEL_PC;
      end
    end
  end

`ifdef MEM_PORT_EXC_LATCH_EN
  logic       exc_q;
  logic       exc_rise;
  logic       pending;
  logic [1:0] pend_code;

  assign exc_rise  = exc_req & ~exc_q;
  // A rise in the COMPLETE cycle itself is chained just like a latched one.
  assign chain_exc = (state == COMPLETE) && (pending || exc_rise);
  assign chain_sel = exc_vec_sel(exc_rise ? exc_code : pend_code);

  // Remember an exception request that rises while the port is busy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exc_q     <= 1'b0;
      pending   <= 1'b0;
      pend_code <= EXC_INVALID;
    end else begin
      exc_q <= exc_req;
      if (chain_exc) begin
        pending <= 1'b0;
      end else if ((state != IDLE) && exc_rise) begin
        pending   <= 1'b1;
        pend_code <= exc_code;
      end
    end
  end
`else
  assign chain_exc = 1'b0;
  assign chain_sel = SEL_VEC253;
`endif

  mem_lat_counter #(
    .CNT_W(CNT_W)
  ) u_lat_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (grant | chain_exc),
    .load_val (LOAD_VAL),
    .dec      (state == ACCESS),
    .zero     (cnt_zero)
  );

  // EPC capture happens in the grant cycle itself; gated so reset forces 0.
  assign epc_wr = ~reset & ((grant && (grant_req == REQ_EXC)) | chain_exc);

  // Main sequencing FSM with registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cur_req     <= REQ_FETCH;
      iord_sel    <= SEL_PC;
      mem_wr      <= 1'b0;
      ir_wr       <= 1'b0;
      mdr_wr      <= 1'b0;
      pc_exc_load <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      mem_wr      <= 1'b0;
      ir_wr       <= 1'b0;
      mdr_wr      <= 1'b0;
      pc_exc_load <= 1'b0;
      done        <= 1'b0;
      case (state)
        IDLE: begin
          if (grant) begin
            state    <= ACCESS;
            cur_req  <= grant_req;
            iord_sel <= grant_sel;
            busy     <= 1'b1;
            mem_wr   <= (grant_req == REQ_STORE);
          end
        end
        ACCESS: begin
          if (cnt_zero) begin
            state       <= COMPLETE;
            done        <= 1'b1;
            ir_wr       <= (cur_req == REQ_FETCH);
            mdr_wr      <= (cur_req == REQ_LOAD);
            pc_exc_load <= (cur_req == REQ_EXC);
          end
        end
        COMPLETE: begin
          if (chain_exc) begin
            state    <= ACCESS;
            cur_req  <= REQ_EXC;
            iord_sel <= chain_sel;
            busy     <= 1'b1;
          end else begin
            state    <= IDLE;
            iord_sel <= SEL_PC;
            busy     <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          iord_sel <= SEL_PC;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_sequencer.sv
// Directed bench for mem_port_sequencer. Two instances share the inputs:
// u_dut2 (MEM_LAT=2) for the main scenarios, u_dut3 (MEM_LAT=3) for the
// exception-latch scenario. Observed vector bit order:
// {busy, done, ir_wr, mdr_wr, pc_exc_load, mem_wr, epc_wr, iord_sel[2:0]}.
module tb_mem_port_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       fetch_req, data_req, data_wr, data_addr_src, exc_req;
  logic [1:0] exc_code;

  logic [2:0] sel2, sel3;
  logic       mem_wr2, ir_wr2, mdr_wr2, epc_wr2, pcx2, busy2, done2;
  logic       mem_wr3, ir_wr3, mdr_wr3, epc_wr3, pcx3, busy3, done3;

  wire [9:0] obs2 = {busy2, done2, ir_wr2, mdr_wr2, pcx2, mem_wr2, epc_wr2, sel2};
  wire [9:0] obs3 = {busy3, done3, ir_wr3, mdr_wr3, pcx3, mem_wr3, epc_wr3, sel3};

  int checks = 0;
  int passed = 0;
  logic [9:0] exp_q[$];
  logic [2:0] req_q[$];  // per cycle {exc_req, data_req, fetch_req}

  mem_port_sequencer #(.MEM_LAT(2), .CNT_W(4)) u_dut2 (
    .clk(clk), .reset(reset), .fetch_req(fetch_req), .data_req(data_req),
    .data_wr(data_wr), .data_addr_src(data_addr_src), .exc_req(exc_req),
    .exc_code(exc_code), .iord_sel(sel2), .mem_wr(mem_wr2), .ir_wr(ir_wr2),
    .mdr_wr(mdr_wr2), .epc_wr(epc_wr2), .pc_exc_load(pcx2), .busy(busy2),
    .done(done2)
  );

  mem_port_sequencer #(.MEM_LAT(3), .CNT_W(4)) u_dut3 (
    .clk(clk), .reset(reset), .fetch_req(fetch_req), .data_req(data_req),
    .data_wr(data_wr), .data_addr_src(data_addr_src), .exc_req(exc_req),
    .exc_code(exc_code), .iord_sel(sel3), .mem_wr(mem_wr3), .ir_wr(ir_wr3),
    .mdr_wr(mdr_wr3), .epc_wr(epc_wr3), .pc_exc_load(pcx3), .busy(busy3),
    .done(done3)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    fetch_req = 1'b1; data_req = 1'b0; data_wr = 1'b0; data_addr_src = 1'b0;
    exc_req = 1'b1; exc_code = 2'b00;
    #2;
    checks++;
    if (obs2 !== 10'b0) $display("FAIL reset_lat2 got=%b exp=%b", obs2, 10'b0);
    else passed++;
    checks++;
    if (obs3 !== 10'b0) $display("FAIL reset_lat3 got=%b exp=%b", obs3, 10'b0);
    else passed++;
    next_cycle();
    fetch_req = 1'b0; exc_req = 1'b0;
    reset = 1'b0;
  endtask

  task automatic test_fetch();
    logic [9:0] exp_v;
    int cyc = 1;
    data_wr = 1'b0; data_addr_src = 1'b0; exc_code = 2'b00;
    req_q = '{3'b001, 3'b000, 3'b000, 3'b000, 3'b000};
    exp_q = '{10'b0000000000, 10'b1000000000, 10'b1000000000,
              10'b1110000000, 10'b0000000000};
    while (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      {exc_req, data_req, fetch_req} = req_q.pop_front();
      @(negedge clk);
      checks++;
      if (obs2 !== exp_v) $display("FAIL fetch c%0d got=%b exp=%b", cyc, obs2, exp_v);
      else passed++;
      next_cycle();
      cyc++;
    end
  endtask

  task automatic test_store();
    logic [9:0] exp_v;
    int cyc = 1;
    data_wr = 1'b1; data_addr_src = 1'b1; exc_code = 2'b00;
    req_q = '{3'b010, 3'b000, 3'b000, 3'b000, 3'b000};
    exp_q = '{10'b0000000000, 10'b1000010010, 10'b1000000010,
              10'b1100000010, 10'b0000000000};
    while (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      {exc_req, data_req, fetch_req} = req_q.pop_front();
      if (cyc == 2) begin
        data_wr = 1'b0;        // late changes must not affect the store
        data_addr_src = 1'b0;
      end
      @(negedge clk);
      checks++;
      if (obs2 !== exp_v) $display("FAIL store c%0d got=%b exp=%b", cyc, obs2, exp_v);
      else passed++;
      next_cycle();
      cyc++;
    end
  endtask

  task automatic test_priority();
    logic [9:0] exp_v;
    int cyc = 1;
    data_wr = 1'b0; data_addr_src = 1'b0; exc_code = 2'b01;
    req_q = '{3'b111, 3'b111, 3'b111, 3'b111,
              3'b011, 3'b011, 3'b011, 3'b011,
              3'b001, 3'b001, 3'b001, 3'b001, 3'b000};
    exp_q = '{10'b0000001000, 10'b1000000100, 10'b1000000100, 10'b1100100100,
              10'b0000000000, 10'b1000000001, 10'b1000000001, 10'b1101000001,
              10'b0000000000, 10'b1000000000, 10'b1000000000, 10'b1110000000,
              10'b0000000000};
    while (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      {exc_req, data_req, fetch_req} = req_q.pop_front();
      @(negedge clk);
      checks++;
      if (obs2 !== exp_v) $display("FAIL priority c%0d got=%b exp=%b", cyc, obs2, exp_v);
      else passed++;
      next_cycle();
      cyc++;
    end
  endtask

  task automatic test_exc_reserved();
    logic [9:0] exp_v;
    int cyc = 1;
    data_wr = 1'b0; data_addr_src = 1'b0; exc_code = 2'b11;
    req_q = '{3'b100, 3'b000, 3'b000, 3'b000, 3'b000};
    exp_q = '{10'b0000001000, 10'b1000000011, 10'b1000000011,
              10'b1100100011, 10'b0000000000};
    while (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      {exc_req, data_req, fetch_req} = req_q.pop_front();
      if (cyc == 2) exc_code = 2'b10;  // ignored while busy
      @(negedge clk);
      checks++;
      if (obs2 !== exp_v) $display("FAIL exc_rsvd c%0d got=%b exp=%b", cyc, obs2, exp_v);
      else passed++;
      next_cycle();
      cyc++;
    end
    exc_code = 2'b00;
  endtask

  task automatic test_reset_mid_access();
    logic [9:0] exp_v;
    int cyc = 1;
    data_wr = 1'b0; data_addr_src = 1'b1; exc_code = 2'b00;
    // Cycle 1: load request; cycle 2: first ACCESS.
    {exc_req, data_req, fetch_req} = 3'b010;
    @(negedge clk);
    checks++;
    if (obs2 !== 10'b0) $display("FAIL rst_mid c1 got=%b exp=%b", obs2, 10'b0);
    else passed++;
    next_cycle();
    data_req = 1'b0;
    @(negedge clk);
    checks++;
    if (obs2 !== 10'b1000000010) $display("FAIL rst_mid c2 got=%b exp=%b", obs2, 10'b1000000010);
    else passed++;
    next_cycle();
    // Cycle 3: second ACCESS, reset asserted mid-cycle.
    reset = 1'b1;
    #1;
    checks++;
    if (obs2 !== 10'b0) $display("FAIL rst_mid async got=%b exp=%b", obs2, 10'b0);
    else passed++;
    next_cycle();
    reset = 1'b0;
    // Two quiet cycles: no done/mdr_wr leaks out of the aborted load.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (obs2 !== 10'b0) $display("FAIL rst_mid quiet%0d got=%b exp=%b", i, obs2, 10'b0);
      else passed++;
      next_cycle();
    end
    // A fresh fetch is granted normally.
    req_q = '{3'b001, 3'b000, 3'b000, 3'b000, 3'b000};
    exp_q = '{10'b0000000000, 10'b1000000000, 10'b1000000000,
              10'b1110000000, 10'b0000000000};
    while (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      {exc_req, data_req, fetch_req} = req_q.pop_front();
      @(negedge clk);
      checks++;
      if (obs2 !== exp_v) $display("FAIL rst_mid refetch c%0d got=%b exp=%b", cyc, obs2, exp_v);
      else passed++;
      next_cycle();
      cyc++;
    end
  endtask

  task automatic test_exc_latch();
    logic [9:0] exp_v;
    int cyc = 1;
    reset = 1'b1;
    {exc_req, data_req, fetch_req} = 3'b000;
    data_wr = 1'b0; data_addr_src = 1'b0; exc_code = 2'b00;
    next_cycle();
    reset = 1'b0;
    req_q = '{3'b001, 3'b000, 3'b100, 3'b000, 3'b000,
              3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
`ifdef MEM_PORT_EXC_LATCH_EN
    exp_q = '{10'b0000000000, 10'b1000000000, 10'b1000000000, 10'b1000000000,
              10'b1110001000, 10'b1000000101, 10'b1000000101, 10'b1000000101,
              10'b1100100101, 10'b0000000000};
`else
    exp_q = '{10'b0000000000, 10'b1000000000, 10'b1000000000, 10'b1000000000,
              10'b1110000000, 10'b0000000000, 10'b0000000000, 10'b0000000000,
              10'b0000000000, 10'b0000000000};
`endif
    while (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      {exc_req, data_req, fetch_req} = req_q.pop_front();
      exc_code = (cyc == 3) ? 2'b10 : 2'b00;
      @(negedge clk);
      checks++;
      if (obs3 !== exp_v) $display("FAIL exc_latch c%0d got=%b exp=%b", cyc, obs3, exp_v);
      else passed++;
      next_cycle();
      cyc++;
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_store();
    test_priority();
    test_exc_reserved();
    test_reset_mid_access();
    test_exc_latch();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
